// File: rtl/conway_cell_update_pipe.sv
// conway_cell_update_pipe: 3-stage registered neighbour adder tree applying the Life rule
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   clear             synchronous flush of every in-flight item
//   in_valid/in_ready input handshake carrying neighbors[7:0] and cell_in
//   out_valid/out_ready output handshake carrying count[3:0] and cell_out
//   result_count      number of completed output handshakes, wraps at 2^CNT_W
module conway_cell_update_pipe #(
    parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
    parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       neighbors,
    input  logic             cell_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       count,
    output logic             cell_out,
    output logic [CNT_W-1:0] result_count
);
    logic v1, v2, v3;
    logic [1:0] p0, p1, p2, p3;
    logic [2:0] q0, q1;
    logic c1, c2;
    logic adv1, adv2, adv3;
    logic [3:0] sum;
    logic nxt;

    // A stage may move when it is empty or its successor is moving.
    assign adv3 = !v3 || out_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;
    // rst_n gates ready so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n && !clear && adv1;
    assign out_valid = v3;
    assign sum = {1'b0, q0} + {1'b0, q1};
    assign nxt = c2 ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
            q0 <= '0;
            q1 <= '0;
            c1 <= 1'b0;
            c2 <= 1'b0;
            count <= '0;
            cell_out <= 1'b0;
            result_count <= '0;
        end else if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (in_valid && adv1) begin
                p0 <= {1'b0, neighbors[0]} + {1'b0, neighbors[1]};
                p1 <= {1'b0, neighbors[2]} + {1'b0, neighbors[3]};
                p2 <= {1'b0, neighbors[4]} + {1'b0, neighbors[5]};
                p3 <= {1'b0, neighbors[6]} + {1'b0, neighbors[7]};
                c1 <= cell_in;
            end
            if (adv2) v2 <= v1;
            if (v1 && adv2) begin
                q0 <= {1'b0, p0} + {1'b0, p1};
                q1 <= {1'b0, p2} + {1'b0, p3};
                c2 <= c1;
            end
            if (adv3) v3 <= v2;
            // Output data only changes when a real item lands, so it holds across bubbles.
            if (v2 && adv3) begin
                count <= sum;
                cell_out <= nxt;
            end
            if (v3 && out_ready) result_count <= result_count + 1'b1;
        end
    end
endmodule
